bcd_addsub_serial: RTL
======================

Name: bcd_addsub_serial

Overview:
- Parametrised, digit-serial, sequential BCD adder/subtractor over DIGITS packed BCD digits.
- Supersedes the fixed 3-digit combinational subtractor: adds an add mode, overflow and invalid-digit flags, a start/busy/done handshake and registered outputs.
- Processes one digit per clock, least-significant digit first.
- Feeds display/score datapaths that hold sign-magnitude BCD.

Parameters:
- DIGITS, 3, number of BCD digits per operand and result (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- op  input  1  0 = a+b, 1 = a−b. Captured with start.
- a  input  4*DIGITS  operand A, packed BCD. Digit 0 is bits [3:0] (ones).
- b  input  4*DIGITS  operand B, same packing.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse: result and flags valid.
- result  output  4*DIGITS  magnitude, packed BCD.
- negative  output  1  sign of result (subtract only).
- overflow  output  1  add carry-out beyond DIGITS digits.
- invalid  output  1  some input nibble was >9.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, negative, overflow, invalid = 0. result = 0. Digit index = 0. carry/borrow = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at a rising edge captures a, b and op into internal registers.
  - If any nibble of a or b is >9: go to DONE with invalid=1, result=0, negative=0, overflow=0.
  - Otherwise go to CALC with index=0 and carry/borrow=0.
- CALC: one digit per cycle for DIGITS cycles.
  - Add: s = a_i + b_i + c. If s>9, digit = s−10 and c=1; else digit = s and c=0.
  - Sub: d = a_i − b_i − c. If d<0, digit = d+10 and c=1; else digit = d and c=0.
  - After the last digit:
    - add: overflow = c, go to DONE.
    - sub with c=0: go to DONE.
    - sub with c=1: negative=1, go to FIX.
- FIX: ten's-complement the stored raw result to get the magnitude, one digit per cycle for DIGITS cycles, LSD first.
  - Per digit: digit = 0 − raw_i − c, borrow-corrected as in CALC, with c starting at 0.
- DONE: done=1 for exactly one cycle, busy=0 on the same cycle, then return to IDLE.
- Output holding:
  - result and flags stay stable from done until the next accepted start.
  - On an accepted start, negative/overflow/invalid clear the following cycle.
- Latency from the start edge to the done cycle:
  - DIGITS+1 for add, or sub with non-negative result.
  - 2*DIGITS+1 for negative sub.
  - 1 for invalid input.
- start while busy or in DONE: ignored. No queueing.
- a, b and op may change after capture without effect.
- Zero result is never negative. a−a gives 0, negative=0.
- Add overflow: result holds the low DIGITS digits (999+001 → 000, overflow=1). overflow is always 0 for sub.
- rst_n asserted mid-operation: immediate return to reset values. No done pulse.
- The next start is accepted on the cycle after done, giving back-to-back operation.

Test Plan:
- DIGITS=3, op=0, a=123, b=456, start 1 cycle → done 4 cycles later. result=579, negative=0, overflow=0.
- op=0, a=999, b=001 → done at +4. result=000, overflow=1.
- op=1, a=456, b=123 → done at +4, result=333, negative=0. op=1, a=123, b=456 → done at +7, result=333, negative=1. op=1, a=b=500 → result=000, negative=0.
- a=1A3 (nibble 0xA), op=1 → done at +1, invalid=1, result=000. Next valid op clears invalid.
- start re-pulsed while busy with different operands → ignored, original result returned.
- Back-to-back start on the cycle after done → accepted.
- rst_n low in the second CALC cycle → all outputs 0 immediately, no done pulse. Operation after release behaves normally.
- Exhaustive sweep with DIGITS=1 and DIGITS=4 (random) against a reference model; check result, sign, flags and latency.

Source files
------------

// File: rtl/bcd_addsub_serial_if.sv
// Operand, request and result bundle for the digit-serial BCD adder/subtractor.
// The master drives the request and the slave (the datapath) drives the results.
interface bcd_addsub_serial_if #(
    parameter int unsigned DIGITS = 3
);
    logic                start;
    logic                op;
    logic [4*DIGITS-1:0] a;
    logic [4*DIGITS-1:0] b;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] result;
    logic                negative;
    logic                overflow;
    logic                invalid;

    modport master (
        output start, op, a, b,
        input  busy, done, result, negative, overflow, invalid
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, negative, overflow, invalid
    );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor, one digit per clock, LSD first, with
// sign-magnitude output and a second ten's-complement pass for negative results.
module bcd_addsub_serial #(
    parameter int unsigned DIGITS = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    bcd_addsub_serial_if.slave  bus
);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e                  state_q, state_d;
    logic [DIGITS-1:0][3:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    op_q, op_d, c_q, c_d;
    logic                    neg_q, neg_d, ovf_q, ovf_d, inv_q, inv_d;
    logic                    busy_q, busy_d, done_q, done_d;

    logic                    bad_digit;
    logic                    last_digit;
    logic                    sub_mode;
    logic [3:0]              x_dig, y_dig, dig_out;
    logic [4:0]              sum;
    logic                    c_out;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign last_digit = (idx_q == IdxW'(DIGITS - 1));

    // Shared digit unit: CALC uses a/b with the captured op, FIX computes 0 - raw.
    always_comb begin
        x_dig    = 4'd0;
        y_dig    = result_q[idx_q];
        sub_mode = 1'b1;
        if (state_q == StCalc) begin
            x_dig    = a_q[idx_q];
            y_dig    = b_q[idx_q];
            sub_mode = op_q;
        end
        if (sub_mode) begin
            sum     = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, c_q};
            c_out   = sum[4];
            dig_out = c_out ? (sum[3:0] + 4'd10) : sum[3:0];
        end else begin
            sum     = {1'b0, x_dig} + {1'b0, y_dig} + {4'd0, c_q};
            c_out   = (sum > 5'd9);
            dig_out = c_out ? (sum[3:0] - 4'd10) : sum[3:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        c_d      = c_q;
        idx_d    = idx_q;
        result_d = result_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    op_d     = bus.op;
                    c_d      = 1'b0;
                    idx_d    = '0;
                    result_d = '0;
                    neg_d    = 1'b0;
                    ovf_d    = 1'b0;
                    inv_d    = bad_digit;
                    state_d  = bad_digit ? StDone : StCalc;
                end
            end
            StCalc: begin
                result_d[idx_q] = dig_out;
                c_d             = c_out;
                idx_d           = idx_q + IdxW'(1);
                if (last_digit) begin
                    c_d   = 1'b0;
                    idx_d = '0;
                    if (!op_q) begin
                        ovf_d   = c_out;
                        state_d = StDone;
                    end else if (c_out) begin
                        // Final borrow: raw result is the ten's complement of the magnitude.
                        neg_d   = 1'b1;
                        state_d = StFix;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFix: begin
                result_d[idx_q] = dig_out;
                c_d             = c_out;
                idx_d           = idx_q + IdxW'(1);
                if (last_digit) begin
                    c_d     = 1'b0;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StCalc) || (state_d == StFix);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.negative = neg_q;
    assign bus.overflow = ovf_q;
    assign bus.invalid  = inv_q;
endmodule
